// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small input FIFO; sends queued words as
// back-to-back frames (start, data, optional parity, 1-2 stop bits).
module uart_tx_fifo #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned MSB_FIRST    = 0,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [DATA_W-1:0]           i_data,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level;
    logic              push, pop, load;
    logic [BW-1:0]     baud, baud_n;
    logic [3:0]        bit_cnt, bit_n;
    logic [DATA_W-1:0] shift, shift_n, shifted;
    logic              par, par_n, tx, tx_n;
    logic              bit_end, first_bit, next_bit, head_par;

    assign o_ready      = (level < FULL);
    assign push         = i_valid && o_ready;
    assign o_fifo_level = level;
    assign o_tx         = tx;
    assign o_busy       = (state != S_IDLE);
    assign bit_end      = (baud == BAUD_LAST);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Bit order is a parameter, so the serial tap and shift direction are fixed.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted   = {shift[DATA_W-2:0], 1'b0};
            first_bit = shift[DATA_W-1];
            next_bit  = shift[DATA_W-2];
        end else begin
            shifted   = {1'b0, shift[DATA_W-1:1]};
            first_bit = shift[0];
            next_bit  = shift[1];
        end
        head_par = (^mem[rd_ptr]) ^ (PARITY == 1);
    end

    always_comb begin
        state_n = state;
        baud_n  = bit_end ? '0 : baud + BW'(1);
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par;
        tx_n    = tx;
        load    = 1'b0;
        o_done  = 1'b0;
        case (state)
            S_IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                load   = (level != '0);
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    tx_n    = first_bit;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_n = bit_cnt + 4'd1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            state_n = S_PARITY;
                            tx_n    = par;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        shift_n = shifted;
                        tx_n    = next_bit;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                    bit_n   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    bit_n = bit_cnt + 4'd1;
                    if (bit_cnt == STOP_LAST) begin
                        o_done  = 1'b1;
                        state_n = S_IDLE;
                        tx_n    = 1'b1;
                        load    = (level != '0);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        // A pop always launches a start bit, whether from idle or straight out of stop.
        if (load) begin
            state_n = S_START;
            shift_n = mem[rd_ptr];
            par_n   = head_par;
            bit_n   = '0;
            baud_n  = '0;
            tx_n    = 1'b0;
        end
        pop = load;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            par     <= par_n;
            tx      <= tx_n;
        end
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised asynchronous-serial transmitter with an input FIFO. It accepts parallel words over a valid/ready handshake, buffers them, and serialises each one as a UART frame: start bit, DATA_W data bits, optional parity, and 1 or 2 stop bits. Every bit is held for a programmable number of clocks. It sits between the character-producing logic and the TX pin, and it sends queued frames back-to-back with no idle gap.

## Interface
Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, clocks per serial bit; legal ≥2.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- MSB_FIRST, 0, data bit order: 0 LSB first, 1 MSB first.
- FIFO_DEPTH, 4, input FIFO entries; power of 2, ≥2.

Ports:
- i_clk  in  1  sole clock; all logic is rising-edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_data  in  DATA_W  word to transmit.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  FIFO can accept a word; high iff level < FIFO_DEPTH.
- o_tx  out  1  serial line, idle high; driven from a register.
- o_busy  out  1  a frame is in progress.
- o_done  out  1  one-cycle pulse on the last clock of each frame's final stop bit.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words currently buffered.

## Operation
- **Push:** a word is accepted on a rising edge where i_valid && o_ready.
  - While o_ready=0, i_data is ignored and i_valid may stay high.
- **Pop:** the FSM pops the FIFO head only from IDLE, or at the end of the final stop bit.
- **Simultaneous push and pop:** the level is unchanged.
- **Push when full:** never accepted. o_ready is computed from the current level only, so a same-cycle pop does not open a slot.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. That edge pops the head into the shift register, loads the bit counter to 0, clears the baud counter, and sets o_tx to 0.
  - START → DATA after CLKS_PER_BIT clocks.
  - DATA: o_tx shows shift[0] when MSB_FIRST=0, or shift[DATA_W-1] when MSB_FIRST=1. The register shifts every CLKS_PER_BIT clocks. DATA exits after DATA_W bits.
  - DATA exits to PARITY if PARITY≠0, otherwise to STOP.
  - PARITY drives one bit. Even mode: XOR of the popped word. Odd mode: its inverse. The parity value is computed at pop time from the unshifted word.
  - STOP drives 1 for STOP_BITS×CLKS_PER_BIT clocks.
  - At the end of STOP: go to START if the FIFO is non-empty (pop, same edge), otherwise go to IDLE.
- **Baud counter:** width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps. Each bit-boundary transition occurs on the edge where count = CLKS_PER_BIT-1.
- **o_busy:** 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- **Reset (any time, including mid-frame):** takes effect immediately with no completion of the current frame.
  - Frame aborted, FIFO emptied, state = IDLE, counters cleared.
  - Outputs: o_tx=1, o_busy=0, o_done=0, o_fifo_level=0, o_ready=1.

## Timing
- **Frame length:** (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT clocks.
- **First-word latency:** with the FIFO empty and the FSM in IDLE, a word pushed at edge E causes o_tx=0 from edge E+1.
- **Back-to-back frames:** the next start bit begins on the clock immediately after the last stop-bit clock, with zero idle cycles.
- **o_done:** asserted during the last clock of STOP; deasserted the following clock.
- **o_fifo_level and o_ready:** update on the push/pop edge; o_ready is combinational from the level.

## Test plan
- **Single frame:** defaults overridden with CLKS_PER_BIT=4, PARITY=2. Push 0xA5 once.
  - o_tx is low for 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each.
  - Then parity 0, then stop 1.
  - o_done pulses once, 44 clocks after the start edge; o_busy then falls.
- **Parity modes:** push 0x01 with PARITY=1 → parity bit 0. With PARITY=2 → parity bit 1. With PARITY=0 → no parity slot, so the frame is 40 clocks.
- **Order and stop bits:** MSB_FIRST=1, DATA_W=7, STOP_BITS=2, PARITY=0, push 0x40.
  - Data bits on o_tx: 1,0,0,0,0,0,0.
  - o_tx then stays high for 8 clocks before o_done.
- **FIFO full and back-to-back:** FIFO_DEPTH=4, push 0x11,0x22,0x33,0x44,0x55 with i_valid held high.
  - The first word is popped immediately, so 0x55 is accepted once the level reaches 3.
  - A sixth word sees o_ready=0 at level 4 and is held off.
  - Five frames are sent contiguously with no idle high gap between them, and o_fifo_level counts down to 0.
- **Reset mid-frame:** drive i_rst low during data bit 3 with 2 words queued.
  - o_tx=1, o_busy=0, o_fifo_level=0, o_ready=1 immediately, without waiting for a clock.
  - After release, pushing 0x3C produces one correct frame.
- **Stall ignore:** while full, change i_data every clock with i_valid=1. Only the words presented on edges where o_ready=1 appear on o_tx.
